output_port_arbiter: RTL and testbench
======================================

# output_port_arbiter

Per-output-port wormhole arbiter for the 3x3 torus router. It takes head-flit requests from the five input directions (Core, E, N, W, S) that route to one output. It grants one requester with round-robin fairness and holds that grant (packet lock) until the tail flit is accepted downstream. One instance sits in front of each of the router's five output buffers, replacing the fixed-priority input scan. It also provides a stall watchdog and a completed-packet counter for debug.

## Interface
Parameters:
- NUM_PORTS, 5, number of input requesters; index order 0=Core, 1=E, 2=N, 3=W, 4=S.
- MAX_STALL, 64, locked cycles without a downstream transfer before `stall_err` asserts; must be ≥1.
- CNT_W, 16, width of `pkt_cnt`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_PORTS  bit i = input i holds a head flit (bit 33) whose route resolves to this output.
- xfer  in  1  downstream `in_ack` for this output this cycle (flit accepted).
- tail  in  1  flit currently on this output has bit 32 set; sampled only with `xfer`.
- grant  out  NUM_PORTS  one-hot registered grant; all-zero when idle.
- grant_idx  out  3  binary index of granted input; 0 when idle.
- busy  out  1  arbiter is locked to a packet.
- stall_err  out  1  watchdog flag.
- pkt_cnt  out  CNT_W  count of completed packets (tail transfers); wraps.

## Operation
- Two-state FSM: IDLE, LOCKED. Round-robin pointer `ptr` (0..NUM_PORTS-1), stall counter `scnt` of width $clog2(MAX_STALL+1).
- IDLE:
  - If `req` is non-zero, select the first set bit scanning ptr, ptr+1, … with wrap mod NUM_PORTS.
  - Register the winner into `grant` and `grant_idx`, set `busy`, go to LOCKED.
  - If `req` is zero, stay in IDLE with all outputs idle.
- LOCKED:
  - `grant` is frozen and `req` is ignored, including a deassert or a change of the granted bit.
  - `xfer && tail`: clear grant, grant_idx and busy; `ptr` ← (grant_idx+1) mod NUM_PORTS; `pkt_cnt` +1 with wrap; `scnt` ← 0; `stall_err` ← 0; go to IDLE.
  - `xfer && !tail`: `scnt` ← 0, stay in LOCKED.
  - `!xfer`: `scnt` increments and saturates at MAX_STALL. `stall_err` ← 1 when `scnt` reaches MAX_STALL; it is sticky until release or reset. The grant is never revoked by the watchdog.
- `tail` while `!xfer` has no effect. `xfer` in IDLE has no effect.
- A single-flit packet (head and tail together) releases on its first `xfer`.

## Timing
- All outputs are registered.
- Reset values: grant=0, grant_idx=0, busy=0, stall_err=0, pkt_cnt=0; internal ptr=0, scnt=0, state=IDLE.
- Grant latency: `req` seen in IDLE at edge t gives `grant` valid after edge t+1.
- Release: `xfer&&tail` at edge t gives grant=0 after t+1.
  - The earliest new grant is after t+2, so there is exactly one idle bubble between packets.
  - A `req` present in the release cycle is not granted in that cycle.
- `stall_err` rises on the edge where the MAX_STALL-th consecutive no-xfer locked cycle is counted.
- Reset asserted mid-packet returns to the reset values on the next edge. The partial packet is abandoned, with no counter increment.

## Structure
- Shared package `router_pkg`:
  - FLIT_W=34, HEAD_BIT=33, TAIL_BIT=32, DST_MSB=27, DST_LSB=24.
  - Port indices PORT_CORE=0, PORT_E=1, PORT_N=2, PORT_W=3, PORT_S=4.
  - FSM state encoding.
- One combinational sub-module `rr_picker`: inputs are the req vector and ptr; outputs are a one-hot winner, its index, and a valid flag. It is reused by a future VC allocator.

## Test plan
- Reset, then req=5'b00100 → grant=5'b00100, grant_idx=2, busy=1 one cycle later; pkt_cnt=0 before the transfer.
- req=5'b11111 held; each packet is 3 flits with xfer every cycle and tail on the 3rd → grant order 0,1,2,3,4,0 with one idle cycle between packets; pkt_cnt=6.
- Locked on input 1; req changes to 5'b10001 mid-packet → grant stays 5'b00010 until tail xfer; the next grant is input 4 (ptr=2, scan 2,3,4).
- MAX_STALL=4, locked, xfer=0 for 4 cycles → stall_err=1 on the 4th; grant is held; a later xfer&&tail clears stall_err and busy.
- Single-flit packet (xfer&&tail on the first locked cycle) → pkt_cnt +1 and grant=0 the next cycle; tail with xfer=0 → no release.
- rst asserted while locked on input 3 → all outputs return to reset values; then req=5'b01000 → grant input 3, because ptr was reset to 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 3x3 torus router: flit layout, port indices, arbiter FSM states.
package router_pkg;

  localparam int unsigned FLIT_W   = 34;
  localparam int unsigned HEAD_BIT = 33;
  localparam int unsigned TAIL_BIT = 32;
  localparam int unsigned DST_MSB  = 27;
  localparam int unsigned DST_LSB  = 24;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_E    = 1;
  localparam int unsigned PORT_N    = 2;
  localparam int unsigned PORT_W    = 3;
  localparam int unsigned PORT_S    = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage : router_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning from ptr upward with wrap.
module rr_picker #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  // Scan ptr, ptr+1, ... mod N and keep the first requester found.
  always_comb begin
    int unsigned k;
    logic [IDX_W-1:0] kk;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    k          = 0;
    kk         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      kk = IDX_W'(k);
      if (!valid && req[kk]) begin
        valid      = 1'b1;
        winner[kk] = 1'b1;
        winner_idx = kk;
      end
    end
  end

endmodule : rr_picker

// File: rtl/output_port_arbiter.sv
// Per-output wormhole arbiter: round-robin grant, packet lock until tail transfer,
// stall watchdog and completed-packet counter.
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned MAX_STALL = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 xfer,
  input  logic                 tail,
  output logic [NUM_PORTS-1:0] grant,
  output logic [2:0]           grant_idx,
  output logic                 busy,
  output logic                 stall_err,
  output logic [CNT_W-1:0]     pkt_cnt
);

  localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned SCNT_W = $clog2(MAX_STALL + 1);

  arb_state_t           state;
  logic [PTR_W-1:0]     ptr;
  logic [SCNT_W-1:0]    scnt;

  logic [NUM_PORTS-1:0] pick_onehot;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (PTR_W)
  ) u_picker (
    .req        (req),
    .ptr        (ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // Grant/lock FSM with watchdog and packet counter; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      scnt      <= '0;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      stall_err <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant     <= pick_onehot;
            grant_idx <= 3'(pick_idx);
            busy      <= 1'b1;
            scnt      <= '0;
            state     <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (xfer && tail) begin
            // Next scan starts just past the input that finished its packet.
            if (grant_idx == 3'(NUM_PORTS - 1)) ptr <= '0;
            else                                 ptr <= PTR_W'(grant_idx + 3'd1);
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            scnt      <= '0;
            stall_err <= 1'b0;
            pkt_cnt   <= pkt_cnt + CNT_W'(1);
            state     <= ARB_IDLE;
          end else if (xfer) begin
            scnt <= '0;
          end else if (scnt != SCNT_W'(MAX_STALL)) begin
            // Saturating stall count; flag is sticky until release.
            scnt <= scnt + SCNT_W'(1);
            if (scnt == SCNT_W'(MAX_STALL - 1)) stall_err <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule : output_port_arbiter

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a packet-level reference model.
module tb_output_port_arbiter;

  localparam int NP    = 5;
  localparam int MS    = 4;
  localparam int CW    = 16;

  logic          clk;
  logic          rst;
  logic [NP-1:0] req;
  logic          xfer;
  logic          tail;
  logic [NP-1:0] grant;
  logic [2:0]    grant_idx;
  logic          busy;
  logic          stall_err;
  logic [CW-1:0] pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  output_port_arbiter #(
    .NUM_PORTS (NP),
    .MAX_STALL (MS),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .xfer      (xfer),
    .tail      (tail),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .stall_err (stall_err),
    .pkt_cnt   (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference model: who owns the output, where the next scan starts,
  // how long the owner has gone without a transfer, how many packets finished.
  int m_busy  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_stall = 0;
  int m_err   = 0;
  int m_pkts  = 0;

  always begin
    logic [NP-1:0] s_req;
    logic s_rst, s_xfer, s_tail;
    int idx;
    @(posedge clk);
    s_rst = rst; s_req = req; s_xfer = xfer; s_tail = tail;
    if (s_rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_stall = 0; m_err = 0; m_pkts = 0;
    end else if (m_busy == 0) begin
      for (int k = 0; k < NP; k++) begin
        idx = (m_ptr + k) % NP;
        if (m_busy == 0 && s_req[idx]) begin
          m_busy = 1; m_owner = idx; m_stall = 0;
        end
      end
    end else if (s_xfer && s_tail) begin
      m_busy = 0; m_ptr = (m_owner + 1) % NP; m_pkts++; m_stall = 0; m_err = 0;
    end else if (s_xfer) begin
      m_stall = 0;
    end else begin
      m_stall++;
      if (m_stall >= MS) m_err = 1;
    end
    #1;
    chk("grant",     int'(grant),     m_busy ? (1 << m_owner) : 0);
    chk("grant_idx", int'(grant_idx), m_busy ? m_owner : 0);
    chk("busy",      int'(busy),      m_busy);
    chk("stall_err", int'(stall_err), m_err);
    chk("pkt_cnt",   int'(pkt_cnt),   m_pkts % (1 << CW));
  end

  // Apply inputs at the falling edge and return at the next falling edge.
  task automatic cyc(input logic [NP-1:0] r, input logic x, input logic t);
    req = r; xfer = x; tail = t;
    @(negedge clk);
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 4, 0};
    rst = 1'b1; req = '0; xfer = 1'b0; tail = 1'b0;
    @(negedge clk);
    cyc('0, 0, 0);
    cyc('0, 0, 0);
    chk("rst_grant",   int'(grant), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_pkt_cnt", int'(pkt_cnt), 0);
    rst = 1'b0;

    // Basic grant latency
    cyc(5'b00100, 0, 0);
    chk("t1_grant",     int'(grant), 4);
    chk("t1_grant_idx", int'(grant_idx), 2);
    chk("t1_busy",      int'(busy), 1);
    chk("t1_pkt_cnt",   int'(pkt_cnt), 0);
    cyc('0, 1, 0);
    cyc('0, 1, 1);
    chk("t1_release", int'(busy), 0);
    chk("t1_pkt_cnt_after", int'(pkt_cnt), 1);

    // Round-robin order with all requesting
    rst = 1'b1; cyc('0, 0, 0); rst = 1'b0;
    for (int p = 0; p < 6; p++) begin
      cyc(5'b11111, 0, 0);
      chk("rr_order", int'(grant_idx), order[p]);
      cyc(5'b11111, 1, 0);
      cyc(5'b11111, 1, 0);
      cyc(5'b11111, 1, 1);
      chk("rr_bubble", int'(grant), 0);
    end
    chk("rr_pkt_cnt", int'(pkt_cnt), 6);

    // Grant frozen against request changes
    cyc(5'b00010, 0, 0);
    chk("lock_grant", int'(grant), 2);
    cyc(5'b10001, 1, 0);
    cyc(5'b10001, 0, 0);
    chk("lock_hold", int'(grant), 2);
    cyc(5'b10001, 1, 1);
    cyc(5'b10001, 0, 0);
    chk("lock_next_idx", int'(grant_idx), 4);

    // Watchdog
    cyc('0, 0, 0); cyc('0, 0, 0); cyc('0, 0, 0);
    chk("stall_pre", int'(stall_err), 0);
    cyc('0, 0, 0);
    chk("stall_set", int'(stall_err), 1);
    chk("stall_grant_held", int'(grant), 16);
    cyc('0, 0, 0);
    cyc('0, 1, 0);
    chk("stall_sticky", int'(stall_err), 1);
    cyc('0, 1, 1);
    chk("stall_clear", int'(stall_err), 0);
    chk("stall_busy_clear", int'(busy), 0);

    // Single-flit packet and tail without transfer
    cyc(5'b00001, 0, 0);
    chk("sf_grant", int'(grant), 1);
    cyc('0, 0, 1);
    chk("sf_tail_noxfer", int'(busy), 1);
    cyc('0, 1, 1);
    chk("sf_release", int'(grant), 0);
    chk("sf_pkt_cnt", int'(pkt_cnt), 9);

    // Reset while locked
    cyc(5'b01000, 0, 0);
    chk("rl_grant", int'(grant_idx), 3);
    rst = 1'b1; cyc(5'b01000, 0, 0); rst = 1'b0;
    chk("rl_grant0", int'(grant), 0);
    chk("rl_busy0",  int'(busy), 0);
    chk("rl_cnt0",   int'(pkt_cnt), 0);
    cyc(5'b01000, 0, 0);
    chk("rl_regrant", int'(grant_idx), 3);
    cyc('0, 1, 1);
    cyc(5'b01010, 0, 0);
    chk("rl_ptr_adv", int'(grant_idx), 1);
    cyc('0, 1, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [NP-1:0] r;
      rst = ($urandom_range(0, 199) == 0);
      r   = NP'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r = '0;
      cyc(r, $urandom_range(0, 9) < 4, $urandom_range(0, 2) == 0);
    end
    rst = 1'b0;
    cyc('0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_output_port_arbiter
